deca4_fetch_decode: RTL

//  Instruction-side counterpart of the deca4 control FSM. Consumes the FSM phase strobes (fetch/exec1/exec2).

---
 rtl/deca4_pkg.sv | 29 ++
 rtl/deca4_opdecode.sv | 40 ++++
 rtl/deca4_fetch_decode.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/deca4_pkg.sv
// deca4_pkg: shared definitions for the deca4 instruction-side logic.
//   - opcode field width and notable opcode values
//   - two-cycle / illegal opcode predicates
//   - fetch state enumeration (IDLE / REQ / HOLD)
package deca4_pkg;

   localparam int unsigned OPCODE_W = 4;

   // Opcodes at or above this value need the second execute phase.
   localparam logic [OPCODE_W-1:0] OP_TWO_CYCLE_MIN = 4'h8;
   // Reserved opcode: illegal when DECA4_ILLEGAL_OP_EN is defined, two-cycle NOP otherwise.
   localparam logic [OPCODE_W-1:0] OP_ILLEGAL = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_e;

   // High for opcodes 8..F (top opcode bit set).
   function automatic logic is_two_cycle(input logic [OPCODE_W-1:0] op);
      return op[OPCODE_W-1];
   endfunction

   function automatic logic is_illegal_op(input logic [OPCODE_W-1:0] op);
      return op == OP_ILLEGAL;
   endfunction

endpackage

// File: rtl/deca4_opdecode.sv
// deca4_opdecode: combinational decode of the held instruction register.
// Configuration macro: DECA4_ILLEGAL_OP_EN (adds illegal_o, suppresses extra for opcode F).
// Ports:
//   ir_i       in   INSTR_W        instruction register contents
//   valid_i    in   1              IR holds a live instruction
//   opcode_o   out  4              ir_i[INSTR_W-1 -: 4]
//   operand_o  out  INSTR_W-4      remaining low bits of ir_i
//   extra_o    out  1              live instruction needs exec2
//   illegal_o  out  1              live instruction is opcode F (macro builds only)
module deca4_opdecode
   import deca4_pkg::*;
#(
   parameter int unsigned INSTR_W = 16
) (
   input  logic [INSTR_W-1:0]          ir_i,
   input  logic                        valid_i,
   output logic [OPCODE_W-1:0]         opcode_o,
   output logic [INSTR_W-OPCODE_W-1:0] operand_o,
`ifdef DECA4_ILLEGAL_OP_EN
   output logic                        illegal_o,
`endif
   output logic                        extra_o
);

   localparam int unsigned OPER_W = INSTR_W - OPCODE_W;

   // Field split
   assign opcode_o  = ir_i[INSTR_W-1 -: OPCODE_W];
   assign operand_o = ir_i[OPER_W-1:0];

`ifdef DECA4_ILLEGAL_OP_EN
   // Illegal words never request exec2.
   assign illegal_o = valid_i & is_illegal_op(opcode_o);
   assign extra_o   = valid_i & is_two_cycle(opcode_o) & ~is_illegal_op(opcode_o);
`else
   // Opcode F is simply another two-cycle (NOP) opcode here.
   assign extra_o   = valid_i & is_two_cycle(opcode_o);
`endif

endmodule

// File: rtl/deca4_fetch_decode.sv
// deca4_fetch_decode: instruction fetch/decode companion of the deca4 control FSM.
// Owns the PC and IR, runs the imem req/ack handshake and feeds 'extra' back to the FSM.
// Configuration macro: DECA4_ILLEGAL_OP_EN (adds sticky illegal_o output).
// Ports:
//   clk_i          in   1              clock, rising edge
//   rst_i          in   1              synchronous active-high reset
//   fetch_i        in   1              FSM fetch strobe
//   exec1_i        in   1              FSM exec1 strobe
//   exec2_i        in   1              FSM exec2 strobe (no effect on PC/IR)
//   extra_o        out  1              held instruction needs exec2 (combinational)
//   imem_req_o     out  1              imem read request
//   imem_addr_o    out  PC_W           imem read address
//   imem_ack_i     in   1              imem read data valid
//   imem_rdata_i   in   INSTR_W        imem read data
//   stall_o        out  1              fetch outstanding (combinational from state)
//   br_take_i      in   1              branch taken (honoured with exec1 in HOLD)
//   br_target_i    in   PC_W           branch destination
//   opcode_o       out  4              opcode of held instruction
//   operand_o      out  INSTR_W-4      operand of held instruction
//   instr_valid_o  out  1              IR holds a live instruction
//   pc_o           out  PC_W           program counter
//   illegal_o      out  1              sticky opcode-F flag (macro builds only)
module deca4_fetch_decode
   import deca4_pkg::*;
#(
   parameter int unsigned PC_W    = 8,
   parameter int unsigned INSTR_W = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        fetch_i,
   input  logic                        exec1_i,
   input  logic                        exec2_i,
   output logic                        extra_o,
   output logic                        imem_req_o,
   output logic [PC_W-1:0]             imem_addr_o,
   input  logic                        imem_ack_i,
   input  logic [INSTR_W-1:0]          imem_rdata_i,
   output logic                        stall_o,
   input  logic                        br_take_i,
   input  logic [PC_W-1:0]             br_target_i,
   output logic [OPCODE_W-1:0]         opcode_o,
   output logic [INSTR_W-OPCODE_W-1:0] operand_o,
   output logic                        instr_valid_o,
`ifdef DECA4_ILLEGAL_OP_EN
   output logic                        illegal_o,
`endif
   output logic [PC_W-1:0]             pc_o
);

   fetch_state_e         state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic [INSTR_W-1:0]   ir_q, ir_d;
   logic                 req_q, req_d;
   logic [PC_W-1:0]      addr_q, addr_d;
   logic                 valid_q, valid_d;

   // exec2 only sequences the datapath; nothing here reacts to it.
   logic unused_exec2;
   assign unused_exec2 = exec2_i;

   // State and datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         req_q   <= 1'b0;
         addr_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         valid_q <= valid_d;
      end
   end

   // Next-state: fetch wins over a same-cycle branch; acks outside REQ are dropped.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      req_d   = req_q;
      addr_d  = addr_q;
      valid_d = valid_q;
      unique case (state_q)
         ST_IDLE, ST_HOLD: begin
            if (fetch_i) begin
               state_d = ST_REQ;
               req_d   = 1'b1;
               addr_d  = pc_q;
               valid_d = 1'b0;
            end else if ((state_q == ST_HOLD) && exec1_i && br_take_i) begin
               pc_d = br_target_i;
            end
         end
         ST_REQ: begin
            if (imem_ack_i) begin
               state_d = ST_HOLD;
               ir_d    = imem_rdata_i;
               pc_d    = pc_q + PC_W'(1);
               req_d   = 1'b0;
               valid_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign stall_o       = (state_q == ST_REQ);
   assign imem_req_o    = req_q;
   assign imem_addr_o   = addr_q;
   assign instr_valid_o = valid_q;
   assign pc_o          = pc_q;

`ifdef DECA4_ILLEGAL_OP_EN
   logic illegal_c;
   logic ill_q, ill_d;

   deca4_opdecode #(.INSTR_W(INSTR_W)) u_opdecode (
      .ir_i      (ir_q),
      .valid_i   (valid_q),
      .opcode_o  (opcode_o),
      .operand_o (operand_o),
      .illegal_o (illegal_c),
      .extra_o   (extra_o)
   );

   // Sticky flag: the live decode covers the cycle the word appears, ill_q holds it after.
   always_ff @(posedge clk_i) begin
      if (rst_i) ill_q <= 1'b0;
      else       ill_q <= ill_d;
   end

   always_comb begin
      ill_d = ill_q | illegal_c;
   end

   assign illegal_o = ill_q | illegal_c;
`else
   deca4_opdecode #(.INSTR_W(INSTR_W)) u_opdecode (
      .ir_i      (ir_q),
      .valid_i   (valid_q),
      .opcode_o  (opcode_o),
      .operand_o (operand_o),
      .extra_o   (extra_o)
   );
`endif

endmodule
